stack_ctrl_seq: RTL and testbench

- Multi-cycle control sequencer that sits directly upstream of the memory/register-file/expression-stack datapath subsystem.
- Accepts 16-bit instruction words over a valid/ready handshake and decodes them.
- Drives the datapath strobes for each instruction: ESOp, ESAct, popNum, pushSrc, push_in, regAddress, regWrite, wea.
- Tracks stack depth and traps on overflow, underflow or an illegal opcode.

---
 rtl/stack_ctrl_pkg.sv | 35 +++
 rtl/stack_ctrl_decode.sv | 52 +++++
 rtl/stack_ctrl_seq.sv | 154 +++++++++++++++
 tb/tb_stack_ctrl_seq.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/stack_ctrl_pkg.sv
// Shared encodings for the expression-stack control sequencer and the datapath it drives.
// The datapath imports the same ESOp/pushSrc constants so both sides agree on the encoding.
package stack_ctrl_pkg;

   localparam logic [3:0] OP_NOP   = 4'h0;
   localparam logic [3:0] OP_PUSHI = 4'h1;
   localparam logic [3:0] OP_LOAD  = 4'h2;
   localparam logic [3:0] OP_STORE = 4'h3;
   localparam logic [3:0] OP_PUSHR = 4'h4;
   localparam logic [3:0] OP_POPR  = 4'h5;
   localparam logic [3:0] OP_HALT  = 4'hF;

   localparam logic [1:0] ES_NONE    = 2'd0;
   localparam logic [1:0] ES_PUSH    = 2'd1;
   localparam logic [1:0] ES_POP     = 2'd2;
   localparam logic [1:0] ES_REPLACE = 2'd3;

   localparam logic [1:0] PS_ZERO = 2'd0;
   localparam logic [1:0] PS_IMM  = 2'd1;
   localparam logic [1:0] PS_MEM  = 2'd2;
   localparam logic [1:0] PS_REG  = 2'd3;

   typedef enum logic [3:0] {
      ST_FETCH  = 4'd0,
      ST_DECODE = 4'd1,
      ST_WRREG  = 4'd2,
      ST_MEMRD  = 4'd3,
      ST_MEMWR  = 4'd4,
      ST_EXEC   = 4'd5,
      ST_SETTLE = 4'd6,
      ST_HALT   = 4'd7,
      ST_ERROR  = 4'd8
   } state_t;

endpackage

// File: rtl/stack_ctrl_decode.sv
// Combinational opcode decode: picks the state to branch to from DECODE, folding in
// opcode legality and the stack-depth preconditions so a trap never issues a strobe.
module stack_ctrl_decode
   import stack_ctrl_pkg::*;
#(
   parameter int STACK_DEPTH = 16,
   parameter int DEPTH_W     = 5
) (
   input  logic [3:0]         opcode,
   input  logic [DEPTH_W-1:0] depth,
   output state_t             branch_state
);

   // Branch target selection with precondition checks
   always_comb begin
      branch_state = ST_ERROR;
      case (opcode)
         OP_NOP:  branch_state = ST_FETCH;
         OP_HALT: branch_state = ST_HALT;
         OP_PUSHI, OP_PUSHR: begin
            if (depth < DEPTH_W'(STACK_DEPTH)) begin
               branch_state = ST_EXEC;
            end else begin
               branch_state = ST_ERROR;
            end
         end
         OP_POPR: begin
            if (depth >= DEPTH_W'(1)) begin
               branch_state = ST_WRREG;
            end else begin
               branch_state = ST_ERROR;
            end
         end
         OP_LOAD: begin
            if (depth >= DEPTH_W'(1)) begin
               branch_state = ST_MEMRD;
            end else begin
               branch_state = ST_ERROR;
            end
         end
         OP_STORE: begin
            if (depth >= DEPTH_W'(2)) begin
               branch_state = ST_MEMWR;
            end else begin
               branch_state = ST_ERROR;
            end
         end
         default: branch_state = ST_ERROR;
      endcase
   end

endmodule

// File: rtl/stack_ctrl_seq.sv
// Multi-cycle control sequencer for the expression-stack datapath. All outputs are
// Moore-decoded from state/IR/depth registers; HALT and ERROR are left only by reset.
module stack_ctrl_seq
   import stack_ctrl_pkg::*;
#(
   parameter int STACK_DEPTH = 16,
   parameter int DW          = 16
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic [DW-1:0]                      instr_in,
   input  logic                               instr_valid,
   output logic                               instr_ready,
   output logic [DW-1:0]                      push_in,
   output logic [1:0]                         pushSrc,
   output logic                               popNum,
   output logic [1:0]                         ESOp,
   output logic                               ESAct,
   output logic [1:0]                         regAddress,
   output logic                               regWrite,
   output logic                               wea,
   output logic                               busy,
   output logic                               halted,
   output logic                               error,
   output logic [$clog2(STACK_DEPTH+1)-1:0]   depth
);

   localparam int DEPTH_W = $clog2(STACK_DEPTH+1);

   state_t               state_q, state_d;
   logic [DW-1:0]        ir_q, ir_d;
   logic [DEPTH_W-1:0]   depth_q, depth_d;
   state_t               branch_state;
   logic [3:0]           opcode;

   assign opcode = ir_q[DW-1:DW-4];
   assign depth  = depth_q;

   stack_ctrl_decode #(
      .STACK_DEPTH (STACK_DEPTH),
      .DEPTH_W     (DEPTH_W)
   ) u_decode (
      .opcode       (opcode),
      .depth        (depth_q),
      .branch_state (branch_state)
   );

   // State, instruction and depth registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_FETCH;
         ir_q    <= {DW{1'b0}};
         depth_q <= {DEPTH_W{1'b0}};
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
         depth_q <= depth_d;
      end
   end

   // Next-state and Moore output decode
   always_comb begin
      state_d     = state_q;
      ir_d        = ir_q;
      depth_d     = depth_q;
      instr_ready = 1'b0;
      push_in     = {DW{1'b0}};
      pushSrc     = PS_ZERO;
      popNum      = 1'b0;
      ESOp        = ES_NONE;
      ESAct       = 1'b0;
      regAddress  = 2'd0;
      regWrite    = 1'b0;
      wea         = 1'b0;
      busy        = 1'b1;
      halted      = 1'b0;
      error       = 1'b0;
      case (state_q)
         ST_FETCH: begin
            busy        = 1'b0;
            instr_ready = 1'b1;
            if (instr_valid) begin
               ir_d    = instr_in;
               state_d = ST_DECODE;
            end else begin
               state_d = ST_FETCH;
            end
         end
         ST_DECODE: state_d = branch_state;
         ST_WRREG: begin
            regWrite   = 1'b1;
            regAddress = ir_q[1:0];
            state_d    = ST_EXEC;
         end
         ST_MEMWR: begin
            wea     = 1'b1;
            state_d = ST_EXEC;
         end
         ST_MEMRD: state_d = ST_EXEC;
         ST_EXEC: begin
            state_d = ST_SETTLE;
            // Only legal, precondition-checked opcodes can reach EXEC
            case (opcode)
               OP_PUSHI: begin
                  ESAct   = 1'b1;
                  ESOp    = ES_PUSH;
                  pushSrc = PS_IMM;
                  push_in = {{(DW-12){ir_q[11]}}, ir_q[11:0]};
                  depth_d = depth_q + DEPTH_W'(1);
               end
               OP_PUSHR: begin
                  ESAct      = 1'b1;
                  ESOp       = ES_PUSH;
                  pushSrc    = PS_REG;
                  regAddress = ir_q[1:0];
                  depth_d    = depth_q + DEPTH_W'(1);
               end
               OP_LOAD: begin
                  ESAct   = 1'b1;
                  ESOp    = ES_REPLACE;
                  pushSrc = PS_MEM;
               end
               OP_POPR: begin
                  ESAct   = 1'b1;
                  ESOp    = ES_POP;
                  popNum  = 1'b0;
                  depth_d = depth_q - DEPTH_W'(1);
               end
               OP_STORE: begin
                  ESAct   = 1'b1;
                  ESOp    = ES_POP;
                  popNum  = 1'b1;
                  depth_d = depth_q - DEPTH_W'(2);
               end
               default: state_d = ST_ERROR;
            endcase
         end
         ST_SETTLE: state_d = ST_FETCH;
         ST_HALT: begin
            busy   = 1'b0;
            halted = 1'b1;
         end
         ST_ERROR: begin
            busy  = 1'b0;
            error = 1'b1;
         end
         default: begin
            busy    = 1'b0;
            state_d = ST_ERROR;
         end
      endcase
   end

endmodule

// File: tb/tb_stack_ctrl_seq.sv
// Self-checking bench for stack_ctrl_seq: fixed vector table, corner-case sequences,
// and random instruction streams checked against a behavioural per-instruction model.
module tb_stack_ctrl_seq;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] instr_in;
   logic        instr_valid;
   logic        instr_ready;
   logic [15:0] push_in;
   logic [1:0]  pushSrc;
   logic        popNum;
   logic [1:0]  ESOp;
   logic        ESAct;
   logic [1:0]  regAddress;
   logic        regWrite;
   logic        wea;
   logic        busy;
   logic        halted;
   logic        error;
   logic [4:0]  depth;

   stack_ctrl_seq #(.STACK_DEPTH(16), .DW(16)) dut (
      .clk(clk), .reset(reset), .instr_in(instr_in), .instr_valid(instr_valid),
      .instr_ready(instr_ready), .push_in(push_in), .pushSrc(pushSrc), .popNum(popNum),
      .ESOp(ESOp), .ESAct(ESAct), .regAddress(regAddress), .regWrite(regWrite),
      .wea(wea), .busy(busy), .halted(halted), .error(error), .depth(depth)
   );

   always #5 clk = ~clk;

   // term: 0 completes, 1 halts, 2 traps. prep: 0 none, 1 wea, 2 regWrite.
   typedef struct packed {
      logic [15:0] instr;
      logic [1:0]  term;
      logic [3:0]  lat;
      logic [1:0]  prep;
      logic [1:0]  esop;
      logic [1:0]  psrc;
      logic [15:0] pin;
      logic        popn;
      logic [1:0]  ra;
      logic [4:0]  dep;
   } vec_t;

   int   checks = 0;
   int   errors = 0;
   int   mdepth = 0;
   vec_t tbl[12];
   vec_t v;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Expected outcome of one instruction issued at stack occupancy d
   function automatic vec_t predict(input logic [15:0] ins, input int d);
      vec_t        r;
      logic [15:0] imm;
      r       = '0;
      r.instr = ins;
      r.dep   = 5'(d);
      imm     = {{4{ins[11]}}, ins[11:0]};
      case (ins[15:12])
         4'h0: r.lat = 4'd2;
         4'h1: if (d < 16) begin
                  r.lat = 4'd4; r.esop = 2'd1; r.psrc = 2'd1; r.pin = imm; r.dep = 5'(d + 1);
               end else r.term = 2'd2;
         4'h4: if (d < 16) begin
                  r.lat = 4'd4; r.esop = 2'd1; r.psrc = 2'd3; r.ra = ins[1:0]; r.dep = 5'(d + 1);
               end else r.term = 2'd2;
         4'h2: if (d >= 1) begin
                  r.lat = 4'd5; r.esop = 2'd3; r.psrc = 2'd2;
               end else r.term = 2'd2;
         4'h5: if (d >= 1) begin
                  r.lat = 4'd5; r.prep = 2'd2; r.ra = ins[1:0]; r.esop = 2'd2; r.dep = 5'(d - 1);
               end else r.term = 2'd2;
         4'h3: if (d >= 2) begin
                  r.lat = 4'd5; r.prep = 2'd1; r.esop = 2'd2; r.popn = 1'b1; r.dep = 5'(d - 2);
               end else r.term = 2'd2;
         4'hF: r.term = 2'd1;
         default: r.term = 2'd2;
      endcase
      return r;
   endfunction

   task automatic do_reset();
      reset       = 1'b1;
      instr_valid = 1'b0;
      instr_in    = 16'h0000;
      repeat (2) @(negedge clk);
      reset  = 1'b0;
      mdepth = 0;
   endtask

   // Issue one instruction (called at a negedge) and watch it cycle by cycle
   task automatic run(input vec_t e);
      int rk = 0, ek = 0, wk = 0, rwk = 0, ec = 0, wc = 0, rwc = 0, excl = 0, rdy_bad = 0;
      logic [1:0]  s_esop = 2'd0, s_psrc = 2'd0, s_ra = 2'd0, s_rwa = 2'd0;
      logic [15:0] s_pin = 16'h0;
      logic        s_popn = 1'b0, busy1 = 1'b0;
      chk("ready_before_issue", 32'(instr_ready), 32'd1);
      instr_in    = e.instr;
      instr_valid = 1'b1;
      @(posedge clk);
      #1;
      if (e.term == 2'd0) instr_valid = 1'b0;
      else instr_in = 16'h1001;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (k == 1) busy1 = busy;
         if (ESAct) begin
            ec++; ek = k; s_esop = ESOp; s_psrc = pushSrc; s_pin = push_in;
            s_popn = popNum; s_ra = regAddress;
         end
         if (wea) begin wc++; wk = k; end
         if (regWrite) begin rwc++; rwk = k; s_rwa = regAddress; end
         if ((int'(ESAct) + int'(wea) + int'(regWrite)) > 1) excl++;
         if (e.term != 2'd0 && instr_ready) rdy_bad++;
         if (e.term == 2'd0 && instr_ready) begin rk = k; break; end
      end
      instr_valid = 1'b0;
      chk("strobe_exclusive", 32'(excl), 32'd0);
      if (e.term == 2'd0) begin
         chk("latency", 32'(rk), 32'(e.lat));
         chk("busy_decode", 32'(busy1), 32'd1);
         chk("busy_after", 32'(busy), 32'd0);
         chk("esact_count", 32'(ec), (e.esop != 2'd0) ? 32'd1 : 32'd0);
         if (e.esop != 2'd0) begin
            chk("esact_cycle", 32'(ek), 32'(e.lat) - 32'd2);
            chk("esop", 32'(s_esop), 32'(e.esop));
            chk("pushsrc", 32'(s_psrc), 32'(e.psrc));
            if (e.psrc == 2'd1) chk("push_in", 32'(s_pin), 32'(e.pin));
            if (e.psrc == 2'd3) chk("exec_regaddr", 32'(s_ra), 32'(e.ra));
            if (e.esop == 2'd2) chk("popnum", 32'(s_popn), 32'(e.popn));
         end
         chk("wea_count", 32'(wc), (e.prep == 2'd1) ? 32'd1 : 32'd0);
         chk("regwrite_count", 32'(rwc), (e.prep == 2'd2) ? 32'd1 : 32'd0);
         if (e.prep == 2'd1) chk("wea_cycle", 32'(wk), 32'(e.lat) - 32'd3);
         if (e.prep == 2'd2) begin
            chk("regwrite_cycle", 32'(rwk), 32'(e.lat) - 32'd3);
            chk("regwrite_addr", 32'(s_rwa), 32'(e.ra));
         end
      end else begin
         chk("term_ready_low", 32'(rdy_bad), 32'd0);
         chk("term_no_strobe", 32'(ec + wc + rwc), 32'd0);
         chk("halted", 32'(halted), (e.term == 2'd1) ? 32'd1 : 32'd0);
         chk("error", 32'(error), (e.term == 2'd2) ? 32'd1 : 32'd0);
      end
      chk("depth", 32'(depth), 32'(e.dep));
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_strobes"}, 32'({ESAct, regWrite, wea, popNum, ESOp, pushSrc, regAddress}), 32'd0);
      chk({tag, "_push_in"}, 32'(push_in), 32'd0);
      chk({tag, "_flags"}, 32'({busy, halted, error}), 32'd0);
      chk({tag, "_depth"}, 32'(depth), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      //            instr     term  lat    prep  esop  psrc  pin       popn  ra    dep
      tbl[0]  = '{16'h17FF, 2'd0, 4'd4, 2'd0, 2'd1, 2'd1, 16'h07FF, 1'b0, 2'd0, 5'd1};
      tbl[1]  = '{16'h1800, 2'd0, 4'd4, 2'd0, 2'd1, 2'd1, 16'hF800, 1'b0, 2'd0, 5'd2};
      tbl[2]  = '{16'h3000, 2'd0, 4'd5, 2'd1, 2'd2, 2'd0, 16'h0000, 1'b1, 2'd0, 5'd0};
      tbl[3]  = '{16'h1010, 2'd0, 4'd4, 2'd0, 2'd1, 2'd1, 16'h0010, 1'b0, 2'd0, 5'd1};
      tbl[4]  = '{16'h1020, 2'd0, 4'd4, 2'd0, 2'd1, 2'd1, 16'h0020, 1'b0, 2'd0, 5'd2};
      tbl[5]  = '{16'h3000, 2'd0, 4'd5, 2'd1, 2'd2, 2'd0, 16'h0000, 1'b1, 2'd0, 5'd0};
      tbl[6]  = '{16'h1005, 2'd0, 4'd4, 2'd0, 2'd1, 2'd1, 16'h0005, 1'b0, 2'd0, 5'd1};
      tbl[7]  = '{16'h5002, 2'd0, 4'd5, 2'd2, 2'd2, 2'd0, 16'h0000, 1'b0, 2'd2, 5'd0};
      tbl[8]  = '{16'h1123, 2'd0, 4'd4, 2'd0, 2'd1, 2'd1, 16'h0123, 1'b0, 2'd0, 5'd1};
      tbl[9]  = '{16'h4002, 2'd0, 4'd4, 2'd0, 2'd1, 2'd3, 16'h0000, 1'b0, 2'd2, 5'd2};
      tbl[10] = '{16'h2000, 2'd0, 4'd5, 2'd0, 2'd3, 2'd2, 16'h0000, 1'b0, 2'd0, 5'd2};
      tbl[11] = '{16'hF000, 2'd1, 4'd0, 2'd0, 2'd0, 2'd0, 16'h0000, 1'b0, 2'd0, 5'd2};

      do_reset();
      chk_reset_outputs("reset");
      chk("reset_ready", 32'(instr_ready), 32'd1);

      for (int i = 0; i < 12; i++) run(tbl[i]);
      do_reset();
      run('{16'h0000, 2'd0, 4'd2, 2'd0, 2'd0, 2'd0, 16'h0000, 1'b0, 2'd0, 5'd0});

      // Underflow: POPR on an empty stack
      do_reset();
      run(predict(16'h5001, 0));

      // Overflow: fill all 16 entries, then one more push
      do_reset();
      for (int i = 0; i < 16; i++) begin
         v = predict(16'h1000 | 16'(i), mdepth);
         run(v);
         mdepth = int'(v.dep);
      end
      chk("full_depth", 32'(depth), 32'd16);
      run(predict(16'h1ABC, mdepth));

      // Illegal opcode
      do_reset();
      run(predict(16'h9123, 0));

      // Reset while LOAD waits in MEMRD
      do_reset();
      run(predict(16'h10AA, 0));
      instr_in = 16'h2000; instr_valid = 1'b1;
      @(posedge clk); #1 instr_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("memrd_busy", 32'(busy), 32'd1);
      #2 reset = 1'b1;
      #1 chk_reset_outputs("rst_memrd");
      @(negedge clk) reset = 1'b0;
      #1 chk("rst_memrd_ready", 32'(instr_ready), 32'd1);
      @(negedge clk);
      mdepth = 0;
      run(predict(16'h1001, 0));

      // Reset cuts a wea strobe in flight
      run(predict(16'h1002, 1));
      instr_in = 16'h3000; instr_valid = 1'b1;
      @(posedge clk); #1 instr_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("memwr_wea", 32'(wea), 32'd1);
      #1 reset = 1'b1;
      #1 chk_reset_outputs("rst_memwr");
      @(negedge clk) reset = 1'b0;

      // Random instruction stream against the model
      do_reset();
      for (int n = 0; n < 400; n++) begin
         int          r;
         logic [15:0] ins;
         logic [3:0]  op;
         r = int'($urandom_range(0, 99));
         if (r < 35)      op = 4'h1;
         else if (r < 45) op = 4'h4;
         else if (r < 57) op = 4'h2;
         else if (r < 67) op = 4'h3;
         else if (r < 79) op = 4'h5;
         else if (r < 89) op = 4'h0;
         else if (r < 95) op = 4'(6 + $urandom_range(0, 8));
         else             op = 4'hF;
         ins = {op, 12'($urandom)};
         v = predict(ins, mdepth);
         run(v);
         if (v.term != 2'd0) do_reset();
         else mdepth = int'(v.dep);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
